riscv_soc_top: RTL and testbench

- Minimal self-contained RV32I SoC top: a single-cycle RV32I core, a writable unified program/data memory (u_rom) and a data RAM (u_ram), all clocked by one clock.
- No external I/O besides clock and reset.
- Software is preloaded into u_rom by hierarchical $readmemh.
- Compliance programs report completion and signature bounds through fixed RAM words.

---
 rtl/riscv_soc_top.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_riscv_soc_top.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_soc_top.sv
// Single-cycle RV32I core with a writable unified ROM (u_rom) and data RAM (u_ram).
// Define SOC_HALT_ON_ECALL_EN to freeze the PC on ECALL/EBREAK until reset.

module soc_rom #(
    parameter int WORDS = 4096
) (
    input  logic        clk,
    input  logic [31:0] fetch_addr,
    output logic [31:0] fetch_data,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    input  logic        we,
    output logic [31:0] rdata
);
    localparam int AW = $clog2(WORDS);

    logic [31:0] _rom [0:WORDS-1];
    logic        unused_addr;

    assign unused_addr = ^{fetch_addr[31:AW+2], fetch_addr[1:0],
                           addr[31:AW+2], addr[1:0]};
    assign fetch_data  = _rom[fetch_addr[AW+1:2]];
    assign rdata       = _rom[addr[AW+1:2]];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) _rom[addr[AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end
endmodule

module soc_ram #(
    parameter int WORDS = 4096
) (
    input  logic        clk,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    input  logic        we,
    output logic [31:0] rdata
);
    localparam int AW = $clog2(WORDS);

    logic [31:0] _ram [0:WORDS-1];
    logic        unused_addr;

    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
    assign rdata       = _ram[addr[AW+1:2]];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) _ram[addr[AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end
endmodule

module riscv_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc,
    input  logic [31:0] instr,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  dbe,
    output logic        dwe,
    input  logic [31:0] drdata
);
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_JAL   = 7'h6f;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_LD    = 7'h03;
    localparam logic [6:0] OP_ST    = 7'h23;
    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP_REG   = 7'h33;

    logic [31:0] regs [0:31];
    logic [31:0] next_pc, wb_data, rv1, rv2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] ld_addr, st_addr, ld_sh;
    logic [15:0] ld_h;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [3:0]  st_be;
    logic        wb_en, halt, is_st;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};

    assign rv1     = regs[rs1];
    assign rv2     = regs[rs2];
    assign ld_addr = rv1 + imm_i;
    assign st_addr = rv1 + imm_s;
    assign is_st   = (opcode == OP_ST);
    assign daddr   = is_st ? st_addr : ld_addr;
    assign ld_sh   = drdata >> {ld_addr[1:0], 3'b000};
    assign ld_h    = ld_addr[1] ? drdata[31:16] : drdata[15:0];

`ifdef SOC_HALT_ON_ECALL_EN
    assign halt = (instr == 32'h0000_0073) || (instr == 32'h0010_0073);
`else
    assign halt = 1'b0;
`endif

    function automatic logic [31:0] alu(input logic [2:0] f, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        alu = '0;
        case (f)
            3'd0: alu = alt ? a - b : a + b;
            3'd1: alu = a << b[4:0];
            3'd2: alu = {31'd0, $signed(a) < $signed(b)};
            3'd3: alu = {31'd0, a < b};
            3'd4: alu = a ^ b;
            3'd5: alu = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: alu = a | b;
            3'd7: alu = a & b;
        endcase
    endfunction

    function automatic logic br_taken(input logic [2:0] f,
                                      input logic [31:0] a, input logic [31:0] b);
        br_taken = 1'b0;
        case (f)
            3'd0: br_taken = (a == b);
            3'd1: br_taken = (a != b);
            3'd4: br_taken = ($signed(a) < $signed(b));
            3'd5: br_taken = ($signed(a) >= $signed(b));
            3'd6: br_taken = (a < b);
            3'd7: br_taken = (a >= b);
            default: br_taken = 1'b0;
        endcase
    endfunction

    always_comb begin
        next_pc = pc + 32'd4;
        wb_en   = 1'b0;
        wb_data = '0;
        dwdata  = '0;
        st_be   = '0;
        unique case (1'b1)
            opcode == OP_LUI: begin
                wb_en   = 1'b1;
                wb_data = imm_u;
            end
            opcode == OP_AUIPC: begin
                wb_en   = 1'b1;
                wb_data = pc + imm_u;
            end
            opcode == OP_JAL: begin
                wb_en   = 1'b1;
                wb_data = pc + 32'd4;
                next_pc = pc + imm_j;
            end
            opcode == OP_JALR: begin
                wb_en   = 1'b1;
                wb_data = pc + 32'd4;
                next_pc = ld_addr & ~32'd1;
            end
            opcode == OP_BR: begin
                if (br_taken(f3, rv1, rv2)) next_pc = pc + imm_b;
            end
            opcode == OP_LD: begin
                wb_en = 1'b1;
                case (f3)
                    3'd0: wb_data = {{24{ld_sh[7]}}, ld_sh[7:0]};
                    3'd1: wb_data = {{16{ld_h[15]}}, ld_h};
                    3'd2: wb_data = drdata;
                    3'd4: wb_data = {24'd0, ld_sh[7:0]};
                    3'd5: wb_data = {16'd0, ld_h};
                    default: wb_en = 1'b0;
                endcase
            end
            opcode == OP_ST: begin
                case (f3)
                    3'd0: begin
                        dwdata = {4{rv2[7:0]}};
                        st_be  = 4'b0001 << st_addr[1:0];
                    end
                    3'd1: begin
                        dwdata = {2{rv2[15:0]}};
                        st_be  = st_addr[1] ? 4'b1100 : 4'b0011;
                    end
                    3'd2: begin
                        dwdata = rv2;
                        st_be  = 4'b1111;
                    end
                    default: st_be = '0;
                endcase
            end
            opcode == OP_IMM: begin
                wb_en   = 1'b1;
                wb_data = alu(f3, (f3 == 3'd5) && instr[30], rv1, imm_i);
            end
            opcode == OP_REG: begin
                wb_en   = 1'b1;
                wb_data = alu(f3, instr[30], rv1, rv2);
            end
            default: ;
        endcase
        if (halt) begin
            next_pc = pc;
            wb_en   = 1'b0;
            st_be   = '0;
        end
    end

    // No stores while reset holds the core, even though memories keep their clock.
    assign dbe = st_be;
    assign dwe = rst_n && (st_be != 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            pc <= next_pc;
            if (wb_en && (rd != 5'd0)) regs[rd] <= wb_data;
        end
    end
endmodule

module riscv_soc_top #(
    parameter int          ROM_WORDS = 4096,
    parameter int          RAM_WORDS = 4096,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input logic clk,
    input logic rst_n
);
    logic [31:0] pc, instr, daddr, dwdata, drdata, rom_rdata, ram_rdata;
    logic [3:0]  dbe;
    logic        dwe, rom_sel, ram_sel;

    assign rom_sel = (daddr[31:28] == 4'h0);
    assign ram_sel = (daddr[31:28] == 4'h1);
    assign drdata  = rom_sel ? rom_rdata : (ram_sel ? ram_rdata : 32'd0);

    riscv_core #(.RESET_PC(RESET_PC)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .pc     (pc),
        .instr  (instr),
        .daddr  (daddr),
        .dwdata (dwdata),
        .dbe    (dbe),
        .dwe    (dwe),
        .drdata (drdata)
    );

    soc_rom #(.WORDS(ROM_WORDS)) u_rom (
        .clk        (clk),
        .fetch_addr (pc),
        .fetch_data (instr),
        .addr       (daddr),
        .wdata      (dwdata),
        .be         (dbe),
        .we         (dwe && rom_sel),
        .rdata      (rom_rdata)
    );

    soc_ram #(.WORDS(RAM_WORDS)) u_ram (
        .clk   (clk),
        .addr  (daddr),
        .wdata (dwdata),
        .be    (dbe),
        .we    (dwe && ram_sel),
        .rdata (ram_rdata)
    );
endmodule

// File: tb/tb_riscv_soc_top.sv
// Directed bench for riscv_soc_top: hand-assembled programs loaded into u_rom,
// registers/PC/memory compared against hand-computed values.

module tb_riscv_soc_top;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst_n;

    riscv_soc_top dut (
        .clk   (clk),
        .rst_n (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] prog [16];
        int          cycles;
        int          target;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [$];
    logic [31:0] p [$];
    logic [31:0] cur [16];
    int          n_vec = 0;
    int          n_bad = 0;

    function automatic logic [31:0] i_t(int imm, int rs1, int f3, int rd, logic [6:0] op);
        logic [31:0] m;
        m = imm;
        return {m[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    function automatic logic [31:0] addi(int rd, int rs1, int imm);
        return i_t(imm, rs1, 0, rd, 7'h13);
    endfunction

    function automatic logic [31:0] ld(int rd, int rs1, int imm, int f3);
        return i_t(imm, rs1, f3, rd, 7'h03);
    endfunction

    function automatic logic [31:0] r_t(int f7, int rs2, int rs1, int f3, int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] s_t(int imm, int rs2, int rs1, int f3);
        logic [31:0] m;
        m = imm;
        return {m[11:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] b_t(int imm, int rs2, int rs1, int f3);
        logic [31:0] m;
        m = imm;
        return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:1], m[11], 7'h63};
    endfunction

    function automatic logic [31:0] jal_t(int rd, int imm);
        logic [31:0] m;
        m = imm;
        return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'h6f};
    endfunction

    function automatic logic [31:0] u_t(int imm20, int rd, logic [6:0] op);
        logic [31:0] m;
        m = imm20;
        return {m[19:0], 5'(rd), op};
    endfunction

    function automatic void add(string nm, int cyc, int tgt, logic [31:0] e);
        vec_t v;
        v.name = nm;
        for (int i = 0; i < 16; i++) v.prog[i] = (i < p.size()) ? p[i] : NOP;
        v.cycles = cyc;
        v.target = tgt;
        v.exp    = e;
        vecs.push_back(v);
    endfunction

    function automatic logic [31:0] probe(int t);
        if (t < 32) return dut.u_core.regs[t];
        if (t == 32) return dut.u_core.pc;
        return dut.u_ram._ram[0];
    endfunction

    function automatic logic [31:0] regs_or();
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) acc |= dut.u_core.regs[i];
        return acc;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic start(int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) dut.u_rom._rom[i] = cur[i];
        @(negedge clk);
        rst_n = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic cur_from_p();
        for (int i = 0; i < 16; i++) cur[i] = (i < p.size()) ? p[i] : NOP;
    endtask

    logic [31:0] gold [3];
    logic        done;

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 128; i++) dut.u_rom._rom[i] = NOP;
        for (int i = 128; i < 256; i++) dut.u_rom._rom[i] = '0;
        for (int i = 0; i < 8; i++) dut.u_ram._ram[i] = '0;
        @(posedge clk);
        #1;
        check("reset_pc", dut.u_core.pc, 32'h0);
        check("reset_regs", regs_or(), 32'h0);

        // ALU and x0
        p = {addi(1, 0, 5), addi(2, 1, -7), r_t(32, 2, 1, 0, 3), addi(0, 0, 1)};
        add("alu_x1", 3, 1, 32'd5);
        add("alu_x2", 3, 2, 32'hFFFF_FFFE);
        add("alu_sub", 3, 3, 32'd7);
        add("alu_pc", 3, 32, 32'd12);
        add("x0_zero", 4, 0, 32'd0);

        // byte/half stores and loads
        p = {u_t(32'h10000, 1, 7'h37), u_t(32'h11223, 2, 7'h37), addi(2, 2, 32'h344),
             s_t(0, 2, 1, 2), addi(3, 0, 32'hAB), s_t(1, 3, 1, 0),
             u_t(32'hD, 4, 7'h37), addi(4, 4, -529), s_t(2, 4, 1, 1),
             ld(5, 1, 1, 0), ld(6, 1, 1, 4), ld(7, 1, 2, 1), ld(8, 1, 0, 2)};
        add("sw_word", 4, 33, 32'h1122_3344);
        add("sb_sh_word", 13, 33, 32'hCDEF_AB44);
        add("lb", 13, 5, 32'hFFFF_FFAB);
        add("lbu", 13, 6, 32'h0000_00AB);
        add("lh", 13, 7, 32'hFFFF_CDEF);
        add("lw", 13, 8, 32'hCDEF_AB44);

        // branches and jumps
        p = {addi(1, 0, 1), addi(2, 0, -1), b_t(8, 0, 0, 0), addi(3, 0, 1),
             b_t(8, 2, 1, 6), addi(4, 0, 1), b_t(8, 2, 1, 4), addi(5, 0, 1),
             jal_t(6, 8), addi(7, 0, 1), jal_t(9, 12), addi(10, 0, 7),
             jal_t(0, 0), i_t(1, 9, 0, 0, 7'h67)};
        add("beq_skip", 12, 3, 32'd0);
        add("bltu_taken", 12, 4, 32'd0);
        add("blt_not", 12, 5, 32'd1);
        add("jal_link", 12, 6, 32'd36);
        add("jal_skip", 12, 7, 32'd0);
        add("jal_link2", 12, 9, 32'd44);
        add("jalr_ret", 12, 10, 32'd7);
        add("br_pc", 12, 32, 32'd48);

        // shifts and compares
        p = {u_t(32'h80000, 1, 7'h37), i_t(32'h404, 1, 5, 2, 7'h13),
             i_t(4, 1, 5, 3, 7'h13), addi(4, 0, 33), addi(5, 0, 3),
             r_t(0, 4, 5, 1, 6), i_t(-1, 5, 3, 7, 7'h13), i_t(-1, 5, 2, 8, 7'h13),
             r_t(0, 5, 1, 2, 9), r_t(32, 4, 1, 5, 10), u_t(1, 11, 7'h17),
             r_t(0, 5, 1, 3, 12)};
        add("srai", 12, 2, 32'hF800_0000);
        add("srli", 12, 3, 32'h0800_0000);
        add("sll_33", 12, 6, 32'd6);
        add("sltiu", 12, 7, 32'd1);
        add("slti", 12, 8, 32'd0);
        add("slt", 12, 9, 32'd1);
        add("sra_33", 12, 10, 32'hC000_0000);
        add("auipc", 12, 11, 32'h0000_1028);
        add("sltu", 12, 12, 32'd0);

        // FENCE / ECALL / EBREAK
        p = {32'h0000_000F, addi(3, 0, 2), 32'h0000_0073, addi(1, 0, 9)};
        add("fence_nop", 4, 3, 32'd2);
`ifdef SOC_HALT_ON_ECALL_EN
        add("ecall_x1", 4, 1, 32'd0);
        add("ecall_pc", 4, 32, 32'd8);
`else
        add("ecall_x1", 4, 1, 32'd9);
        add("ecall_pc", 4, 32, 32'd16);
`endif

        for (int v = 0; v < vecs.size(); v++) begin
            cur = vecs[v].prog;
            start(vecs[v].cycles);
            check(vecs[v].name, probe(vecs[v].target), vecs[v].exp);
        end

        // asynchronous reset between edges
        p = {u_t(32'h10000, 1, 7'h37), u_t(32'h11223, 2, 7'h37), addi(2, 2, 32'h344),
             s_t(0, 2, 1, 2), addi(3, 0, 32'hAB), s_t(1, 3, 1, 0),
             u_t(32'hD, 4, 7'h37), addi(4, 4, -529), s_t(2, 4, 1, 1)};
        cur_from_p();
        start(12);
        check("pre_rst_x1", dut.u_core.regs[1], 32'h1000_0000);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_pc", dut.u_core.pc, 32'h0);
        check("arst_regs", regs_or(), 32'h0);
        check("arst_mem", dut.u_ram._ram[0], 32'hCDEF_AB44);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("restart_x1", dut.u_core.regs[1], 32'h1000_0000);
        check("restart_pc", dut.u_core.pc, 32'd4);

        // compliance-style flow: signature in u_rom, bounds and done flag in u_ram
        for (int i = 128; i < 136; i++) dut.u_rom._rom[i] = '0;
        for (int i = 2; i < 5; i++) dut.u_ram._ram[i] = '0;
        p = {u_t(32'h10000, 1, 7'h37), addi(2, 0, 32'h200), addi(3, 0, 32'h20C),
             s_t(8, 2, 1, 2), s_t(12, 3, 1, 2), addi(4, 0, -5),
             s_t(0, 4, 2, 2), s_t(4, 4, 2, 0), s_t(10, 4, 2, 1),
             addi(5, 0, 1), s_t(16, 5, 1, 2), jal_t(0, 0)};
        gold[0] = 32'hFFFF_FFFB;
        gold[1] = 32'h0000_00FB;
        gold[2] = 32'hFFFB_0000;
        cur_from_p();
        start(0);
        done = 1'b0;
        for (int c = 0; c < 25000 && !done; c++) begin
            @(posedge clk);
            #1;
            done = (dut.u_ram._ram[4] == 32'd1);
        end
        check("cmp_done", dut.u_ram._ram[4], 32'd1);
        check("cmp_begin", dut.u_ram._ram[2], 32'h200);
        check("cmp_end", dut.u_ram._ram[3], 32'h20C);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("cmp_sig%0d", k), dut.u_rom._rom[128 + k], gold[k]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
